id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: decode-side handshake.
REQ-005 SHALL have input decode fields: in_alu_ctrl (alu_t), in_rs1_addr 5, in_rs2_addr 5, in_rs1_data 32, in_rs2_data 32, in_imm 32, in_use_imm 1, in_rd_addr 5, in_rd_we 1, in_is_load 1.
REQ-006 SHALL have forwarding inputs: exm_rd_addr 5, exm_rd_we 1, exm_result 32, wb_rd_addr 5, wb_rd_we 1, wb_data 32.
REQ-007 SHALL have port flush  input  1  discard the held and incoming instruction (branch/jump redirect).
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1: execute-side handshake.
REQ-009 SHALL have outputs out_alu_ctrl (alu_t), out_op1 32, out_op2 32 driving the ALU, plus out_store_data 32, out_rd_addr 5, out_rd_we 1, out_is_load 1.

Function
REQ-010 SHALL hold one instruction in a stage register; valid bit v drives out_valid.
REQ-011 SHALL accept (load register) when in_valid && in_ready; in_ready = (!v || out_ready) && !hazard && !flush.
REQ-012 SHALL clear v when out_ready && v and no instruction is accepted in that cycle (bubble).
REQ-013 SHALL hold all registered fields when v && !out_ready.
REQ-014 SHALL compute load-use hazard = in_valid && v && out_is_load && out_rd_we && out_rd_addr!=0 && (in_rs1_addr==out_rd_addr || in_rs2_addr==out_rd_addr); hazard inserts exactly one bubble.
REQ-015 SHALL forward per source: EX/MEM match (we, addr!=0, addr==rs) has priority over MEM/WB match; else registered register-file data.
REQ-016 SHALL never forward for address 0; x0 operand reads 0 regardless of rs data.
REQ-017 SHALL drive out_op1 = forwarded rs1; out_op2 = in_use_imm-registered ? imm : forwarded rs2; out_store_data = forwarded rs2 always.
REQ-018 SHALL, while held (v && !out_ready), write forwarded rs1/rs2 values back into the operand registers each cycle so values survive producer retirement.
REQ-019 SHALL give flush priority over accept and hold: v <= 0 next cycle; in_ready = 0 in the flush cycle.
REQ-020 SHALL have latency one cycle from accept to out_valid; forwarding path is combinational.

Reset
REQ-021 SHALL on rst clear v; out_valid=0, out_rd_we=0, out_is_load=0, out_alu_ctrl=ADD, all data outputs 0.
REQ-022 SHALL have reset override flush and all handshakes; in_ready=0 during the reset cycle.

Configuration
REQ-023 SHALL, with FORWARDING_EN defined, implement REQ-014..REQ-018 as written.
REQ-024 SHALL, without FORWARDING_EN, use raw registered operands and extend hazard to any rs match (addr!=0) against stage rd, exm_rd or wb_rd with write-enable set; stall until cleared.

Structure
REQ-025 SHALL take alu_t and its encodings from the shared riscv_types package; a fwd_sel_t enum (NONE, EXM, WB) SHALL be added there.
REQ-026 SHALL instantiate one sub-module fwd_mux (per-source forwarding select), used twice.

Verification
REQ-027 ADD x3 after ADDI x1 in stage (exm_rd=1, exm_result=5) -> out_op1=5 same cycle.
REQ-028 exm and wb both target rs1=2 (exm_result=7, wb_data=9) -> out_op1=7; rs=0 with exm_rd=0, exm_result=7 -> out_op1=0.
REQ-029 LW x4 in stage, incoming reads x4 -> in_ready=0 one cycle, out_valid=0 next, then accepts.
REQ-030 out_ready=0 for 3 cycles with wb forwarding value 0x55 in cycle 1 only -> out_op2 stays 0x55.
REQ-031 flush asserted with in_valid=1 and v=1 -> out_valid=0 next cycle, incoming not captured; rst mid-stall -> all outputs per REQ-021.

Source files
------------

// File: rtl/riscv_types_pkg.sv
// Shared RISC-V pipeline types: ALU opcodes, forwarding-source select and a
// register-match helper used by the hazard and forwarding logic.
package riscv_types;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } alu_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EXM  = 2'd1,
        WB   = 2'd2
    } fwd_sel_t;

    // True when a writer (rd, we) produces the register a reader names; x0 never matches.
    function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rd,
                                     input logic                  we,
                                     input logic [REG_ADDR_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand select: EX/MEM result beats MEM/WB data beats the
// register-file value; x0 always reads zero. EN=0 leaves only the x0 rule.
module fwd_mux
    import riscv_types::*;
#(
    parameter int XLEN = 32,
    parameter bit EN   = 1'b1
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [4:0]      exm_rd_addr,
    input  logic            exm_rd_we,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    fwd_sel_t sel;

    // Pick the youngest producer of rs_addr.
    always_comb begin
        sel = NONE;
        if (EN && reg_hit(exm_rd_addr, exm_rd_we, rs_addr)) begin
            sel = EXM;
        end else if (EN && reg_hit(wb_rd_addr, wb_rd_we, rs_addr)) begin
            sel = WB;
        end
    end

    // Drive the operand from the chosen source, forcing zero for x0.
    always_comb begin
        data = rs_data;
        case (sel)
            EXM:     data = exm_result;
            WB:      data = wb_data;
            default: data = rs_data;
        endcase
        if (rs_addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// Build option FORWARDING_EN: when defined, operands are forwarded from
// EX/MEM and MEM/WB and only a load-use dependency stalls; when undefined,
// operands are taken raw and any pending writer of a source stalls decode.
module id_ex_stage
    import riscv_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_t            in_alu_ctrl,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic [4:0]      exm_rd_addr,
    input  logic            exm_rd_we,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output alu_t            out_alu_ctrl,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_we,
    output logic            out_is_load
);

`ifdef FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic            v;
    alu_t            alu_q;
    logic [4:0]      rs1_addr_q;
    logic [4:0]      rs2_addr_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic            use_imm_q;
    logic [4:0]      rd_addr_q;
    logic            rd_we_q;
    logic            is_load_q;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            hazard;
    logic            accept;
    logic            hold;

    fwd_mux #(.XLEN(XLEN), .EN(FWD_EN)) u_fwd_rs1 (
        .rs_addr     (rs1_addr_q),
        .rs_data     (rs1_q),
        .exm_rd_addr (exm_rd_addr),
        .exm_rd_we   (exm_rd_we),
        .exm_result  (exm_result),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .wb_data     (wb_data),
        .data        (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .EN(FWD_EN)) u_fwd_rs2 (
        .rs_addr     (rs2_addr_q),
        .rs_data     (rs2_q),
        .exm_rd_addr (exm_rd_addr),
        .exm_rd_we   (exm_rd_we),
        .exm_result  (exm_result),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .wb_data     (wb_data),
        .data        (rs2_fwd)
    );

    // Decide whether the incoming instruction must wait for a producer.
    always_comb begin
        hazard = 1'b0;
`ifdef FORWARDING_EN
        // Only a load in this stage cannot be forwarded in time: one bubble.
        hazard = in_valid && v && is_load_q &&
                 (reg_hit(rd_addr_q, rd_we_q, in_rs1_addr) ||
                  reg_hit(rd_addr_q, rd_we_q, in_rs2_addr));
`else
        // Without bypass, wait until no in-flight writer targets a source.
        hazard = in_valid &&
                 ((v && (reg_hit(rd_addr_q, rd_we_q, in_rs1_addr) ||
                         reg_hit(rd_addr_q, rd_we_q, in_rs2_addr))) ||
                  reg_hit(exm_rd_addr, exm_rd_we, in_rs1_addr) ||
                  reg_hit(exm_rd_addr, exm_rd_we, in_rs2_addr) ||
                  reg_hit(wb_rd_addr, wb_rd_we, in_rs1_addr) ||
                  reg_hit(wb_rd_addr, wb_rd_we, in_rs2_addr));
`endif
    end

    assign in_ready = !rst && (!v || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign hold     = v && !out_ready;

    // Stage register: reset, then flush, then accept, then hold, else drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            v          <= 1'b0;
            alu_q      <= ADD;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (accept) begin
            v          <= 1'b1;
            alu_q      <= in_alu_ctrl;
            rs1_addr_q <= in_rs1_addr;
            rs2_addr_q <= in_rs2_addr;
            rs1_q      <= in_rs1_data;
            rs2_q      <= in_rs2_data;
            imm_q      <= in_imm;
            use_imm_q  <= in_use_imm;
            rd_addr_q  <= in_rd_addr;
            rd_we_q    <= in_rd_we;
            is_load_q  <= in_is_load;
        end else if (hold) begin
            // Capture bypassed values so they outlive the producer retiring.
            if (FWD_EN) begin
                rs1_q <= rs1_fwd;
                rs2_q <= rs2_fwd;
            end
        end else begin
            v <= 1'b0;
        end
    end

    assign out_valid      = v;
    assign out_alu_ctrl   = alu_q;
    assign out_op1        = rs1_fwd;
    assign out_op2        = use_imm_q ? imm_q : rs2_fwd;
    assign out_store_data = rs2_fwd;
    assign out_rd_addr    = rd_addr_q;
    assign out_rd_we      = rd_we_q;
    assign out_is_load    = is_load_q;

endmodule
